// File: rtl/mul_acc_pipe.sv
// mul_acc_pipe: pipelined A x B multiplier with frame-delimited running
// accumulation, valid/ready handshake and optional accumulator saturation.
//
// Ports:
//   clk, reset_n      rising-edge clock, asynchronous active-low reset
//   ce                global clock enable; low freezes every register
//   in_valid/in_ready input handshake (in_ready = advance)
//   din0, din1        operands (signedness per SIGNED_A / SIGNED_B)
//   in_first/in_last  accumulation frame markers for the input beat
//   out_valid/out_ready output handshake
//   dout_p            product of the output beat (P_WIDTH, extended/truncated)
//   dout_acc          running sum including the output beat
//   out_last          in_last carried with the beat
//   acc_ovf           sticky overflow/saturation flag of current accumulation
module mul_acc_pipe #(
  parameter int unsigned A_WIDTH   = 8,
  parameter int unsigned B_WIDTH   = 14,
  parameter int unsigned P_WIDTH   = 22,
  parameter int unsigned NUM_STAGE = 4,   // legal 2..8
  parameter int unsigned SIGNED_A  = 0,
  parameter int unsigned SIGNED_B  = 0,
  parameter int unsigned ACC_WIDTH = 32,  // must be >= P_WIDTH
  parameter int unsigned SAT_EN    = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ce,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   din0,
  input  logic [B_WIDTH-1:0]   din1,
  input  logic                 in_first,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [P_WIDTH-1:0]   dout_p,
  output logic [ACC_WIDTH-1:0] dout_acc,
  output logic                 out_last,
  output logic                 acc_ovf
);

  localparam int unsigned PW  = A_WIDTH + B_WIDTH;
  localparam int unsigned AW1 = ACC_WIDTH + 1;
  localparam int unsigned NS  = NUM_STAGE;
  localparam logic PROD_SIGNED = (SIGNED_A != 0) || (SIGNED_B != 0);
  localparam logic SAT         = (SAT_EN != 0);

  logic               w_adv;
  logic               r_out_vld;
  logic               r_vld1, r_first1, r_last1;
  logic [A_WIDTH-1:0] r_a;
  logic [B_WIDTH-1:0] r_b;
  logic [PW-1:0]      w_a_ext, w_b_ext, w_prod_s1;
  logic               w_fin_v, w_fin_f, w_fin_l;
  logic [PW-1:0]      w_fin_p;

  // Whole pipeline moves as one unit; blocked only by ce or a stalled output.
  assign w_adv     = ce & (~r_out_vld | out_ready);
  assign in_ready  = w_adv & reset_n;
  assign out_valid = r_out_vld;

  // Stage 1: operand capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld1   <= 1'b0;
      r_first1 <= 1'b0;
      r_last1  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
    end else if (w_adv) begin
      r_vld1 <= in_valid;
      if (in_valid) begin
        r_first1 <= in_first;
        r_last1  <= in_last;
        r_a      <= din0;
        r_b      <= din1;
      end
    end
  end

  // Operand extension to full product width; a PW-bit modular multiply then
  // yields the exact signed/unsigned product.
  if (SIGNED_A != 0) begin : g_sa
    assign w_a_ext = {{B_WIDTH{r_a[A_WIDTH-1]}}, r_a};
  end else begin : g_ua
    assign w_a_ext = {{B_WIDTH{1'b0}}, r_a};
  end

  if (SIGNED_B != 0) begin : g_sb
    assign w_b_ext = {{A_WIDTH{r_b[B_WIDTH-1]}}, r_b};
  end else begin : g_ub
    assign w_b_ext = {{A_WIDTH{1'b0}}, r_b};
  end

  assign w_prod_s1 = w_a_ext * w_b_ext;

  // Stages 2..NS-1: product register and retiming
  for (genvar s = 2; s < NS; s++) begin : g_st
    logic          r_v, r_f, r_l;
    logic [PW-1:0] r_p;
    logic          w_v, w_f, w_l;
    logic [PW-1:0] w_p;

    if (s == 2) begin : g_src
      assign w_v = r_vld1;
      assign w_f = r_first1;
      assign w_l = r_last1;
      assign w_p = w_prod_s1;
    end else begin : g_src
      assign w_v = g_st[s-1].r_v;
      assign w_f = g_st[s-1].r_f;
      assign w_l = g_st[s-1].r_l;
      assign w_p = g_st[s-1].r_p;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_v <= 1'b0;
        r_f <= 1'b0;
        r_l <= 1'b0;
        r_p <= '0;
      end else if (w_adv) begin
        r_v <= w_v;
        if (w_v) begin
          r_f <= w_f;
          r_l <= w_l;
          r_p <= w_p;
        end
      end
    end
  end

  // Beat presented to the output/accumulate stage
  if (NS > 2) begin : g_fin
    assign w_fin_v = g_st[NS-1].r_v;
    assign w_fin_f = g_st[NS-1].r_f;
    assign w_fin_l = g_st[NS-1].r_l;
    assign w_fin_p = g_st[NS-1].r_p;
  end else begin : g_fin
    assign w_fin_v = r_vld1;
    assign w_fin_f = r_first1;
    assign w_fin_l = r_last1;
    assign w_fin_p = w_prod_s1;
  end

  logic [P_WIDTH-1:0]   w_p_out;
  logic [AW1-1:0]       w_p_x, w_base_x, w_sum;
  logic [ACC_WIDTH-1:0] w_base, w_sat, w_acc_nxt;
  logic                 w_ovf;

  // Product resized to P_WIDTH: LSBs kept, or extended by product signedness
  if (P_WIDTH <= PW) begin : g_ptrunc
    assign w_p_out = w_fin_p[P_WIDTH-1:0];
  end else begin : g_pext
    assign w_p_out = {{(P_WIDTH-PW){PROD_SIGNED & w_fin_p[PW-1]}}, w_fin_p};
  end

  // Sum in ACC_WIDTH+1 bits so the extra bit exposes overflow
  assign w_p_x     = {{(AW1-P_WIDTH){PROD_SIGNED & w_p_out[P_WIDTH-1]}}, w_p_out};
  assign w_base    = w_fin_f ? '0 : dout_acc;
  assign w_base_x  = {PROD_SIGNED & w_base[ACC_WIDTH-1], w_base};
  assign w_sum     = w_base_x + w_p_x;
  assign w_ovf     = PROD_SIGNED ? (w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1]) : w_sum[ACC_WIDTH];
  // Signed clamp direction follows the true sign held in the extra bit
  assign w_sat     = PROD_SIGNED ? {w_sum[ACC_WIDTH], {(ACC_WIDTH-1){~w_sum[ACC_WIDTH]}}}
                                 : {ACC_WIDTH{1'b1}};
  assign w_acc_nxt = (SAT && w_ovf) ? w_sat : w_sum[ACC_WIDTH-1:0];

  // Stage NS: output/accumulate register; bubbles leave results untouched
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_vld <= 1'b0;
      dout_p    <= '0;
      dout_acc  <= '0;
      out_last  <= 1'b0;
      acc_ovf   <= 1'b0;
    end else if (w_adv) begin
      r_out_vld <= w_fin_v;
      if (w_fin_v) begin
        dout_p   <= w_p_out;
        dout_acc <= w_acc_nxt;
        out_last <= w_fin_l;
        acc_ovf  <= (~w_fin_f & acc_ovf) | w_ovf;
      end
    end
  end

endmodule

// File: tb/tb_mul_acc_pipe.sv
// Testbench for mul_acc_pipe: four configurations share one stimulus stream;
// a reference model computes expected results at issue time into a queue and
// a monitor pops and compares on every output transfer.
module tb_mul_acc_pipe;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic [7:0]  din0 = '0;
  logic [13:0] din1 = '0;

  always #5 clk = ~clk;

  logic [3:0]  ir, ov, ol, ovf;
  logic [21:0] p_u, p_s;
  logic [31:0] acc_u;
  logic [23:0] acc_s;
  logic [15:0] p_t, acc_t, p_w, acc_w;
  logic [3:0][31:0] gp, ga;

  assign gp[0] = 32'(p_u);
  assign gp[1] = 32'(p_s);
  assign gp[2] = 32'(p_t);
  assign gp[3] = 32'(p_w);
  assign ga[0] = acc_u;
  assign ga[1] = 32'(acc_s);
  assign ga[2] = 32'(acc_t);
  assign ga[3] = 32'(acc_w);

  // cfg0: defaults, cfg1: signed A + 24b saturating, cfg2: 16b unsigned
  // saturating, cfg3: signed B + 16b wrapping
  mul_acc_pipe #(.A_WIDTH(8), .B_WIDTH(14), .P_WIDTH(22), .NUM_STAGE(4), .SIGNED_A(0),
                 .SIGNED_B(0), .ACC_WIDTH(32), .SAT_EN(0)) u_dut_u (
    .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .in_ready(ir[0]),
    .din0(din0), .din1(din1), .in_first(in_first), .in_last(in_last), .out_valid(ov[0]),
    .out_ready(out_ready), .dout_p(p_u), .dout_acc(acc_u), .out_last(ol[0]), .acc_ovf(ovf[0]));

  mul_acc_pipe #(.A_WIDTH(8), .B_WIDTH(14), .P_WIDTH(22), .NUM_STAGE(4), .SIGNED_A(1),
                 .SIGNED_B(0), .ACC_WIDTH(24), .SAT_EN(1)) u_dut_s (
    .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .in_ready(ir[1]),
    .din0(din0), .din1(din1), .in_first(in_first), .in_last(in_last), .out_valid(ov[1]),
    .out_ready(out_ready), .dout_p(p_s), .dout_acc(acc_s), .out_last(ol[1]), .acc_ovf(ovf[1]));

  mul_acc_pipe #(.A_WIDTH(8), .B_WIDTH(14), .P_WIDTH(16), .NUM_STAGE(4), .SIGNED_A(0),
                 .SIGNED_B(0), .ACC_WIDTH(16), .SAT_EN(1)) u_dut_t (
    .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .in_ready(ir[2]),
    .din0(din0), .din1(din1), .in_first(in_first), .in_last(in_last), .out_valid(ov[2]),
    .out_ready(out_ready), .dout_p(p_t), .dout_acc(acc_t), .out_last(ol[2]), .acc_ovf(ovf[2]));

  mul_acc_pipe #(.A_WIDTH(8), .B_WIDTH(14), .P_WIDTH(16), .NUM_STAGE(4), .SIGNED_A(0),
                 .SIGNED_B(1), .ACC_WIDTH(16), .SAT_EN(0)) u_dut_w (
    .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid), .in_ready(ir[3]),
    .din0(din0), .din1(din1), .in_first(in_first), .in_last(in_last), .out_valid(ov[3]),
    .out_ready(out_ready), .dout_p(p_w), .dout_acc(acc_w), .out_last(ol[3]), .acc_ovf(ovf[3]));

  localparam int CSA[4]  = '{0, 1, 0, 0};
  localparam int CSB[4]  = '{0, 0, 0, 1};
  localparam int CP[4]   = '{22, 22, 16, 16};
  localparam int CACC[4] = '{32, 24, 16, 16};
  localparam int CSAT[4] = '{0, 1, 1, 0};

  typedef struct packed {
    logic [3:0][31:0] p;
    logic [3:0][31:0] acc;
    logic [3:0]       ovf;
    logic             last;
  } exp_t;

  exp_t   q[$];
  longint m_acc[4];
  bit     m_ovf[4];
  int     n_chk = 0;
  int     n_err = 0;
  int     beat_no = 0;
  int     stall_left = 0;
  bit     stall_arm = 0;
  bit     rand_bp = 0;
  bit     rand_ce = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // Reference model: integer arithmetic on true values, range-checked
  function automatic exp_t model(input int unsigned a, input int unsigned b,
                                 input bit f, input bit l);
    exp_t e;
    e = '0;
    e.last = l;
    for (int c = 0; c < 4; c++) begin
      longint av, bv, prod, pmod, pm, pv, amod, lo, hi, sum;
      bit     ps, o;
      av   = (CSA[c] != 0 && a >= 128)  ? longint'(a) - 256   : longint'(a);
      bv   = (CSB[c] != 0 && b >= 8192) ? longint'(b) - 16384 : longint'(b);
      prod = av * bv;
      pmod = longint'(1) << CP[c];
      pm   = prod & (pmod - 1);
      ps   = (CSA[c] != 0) || (CSB[c] != 0);
      pv   = (ps && pm >= pmod / 2) ? pm - pmod : pm;
      amod = longint'(1) << CACC[c];
      lo   = ps ? -(amod / 2) : longint'(0);
      hi   = ps ? amod / 2 - 1 : amod - 1;
      sum  = (f ? longint'(0) : m_acc[c]) + pv;
      o    = (sum < lo) || (sum > hi);
      if (o) begin
        if (CSAT[c] != 0) sum = (sum < lo) ? lo : hi;
        else begin
          sum = sum & (amod - 1);
          if (ps && sum >= amod / 2) sum = sum - amod;
        end
      end
      m_acc[c]  = sum;
      m_ovf[c]  = (f ? 1'b0 : m_ovf[c]) | o;
      e.p[c]    = 32'(pm);
      e.acc[c]  = 32'(sum & (amod - 1));
      e.ovf[c]  = m_ovf[c];
    end
    return e;
  endfunction

  task automatic reset_model();
    for (int c = 0; c < 4; c++) begin
      m_acc[c] = 0;
      m_ovf[c] = 1'b0;
    end
    q.delete();
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance
  task automatic send(input int unsigned a, input int unsigned b, input bit f,
                      input bit l, input bit must_rdy);
    int guard = 0;
    bit done = 1'b0;
    bit first_try = must_rdy;
    din0 = 8'(a); din1 = 14'(b); in_first = f; in_last = l; in_valid = 1'b1;
    while (!done) begin
      if (rand_ce) ce = ($urandom_range(0, 4) != 0);
      #1;
      if (first_try) begin
        chk("in_ready_b2b", 32'(ir[0]), 32'd1);
        first_try = 1'b0;
      end
      if (ir[0]) begin
        q.push_back(model(a, b, f, l));
        done = 1'b1;
      end
      @(negedge clk);
      guard++;
      if (!done && guard > 200) begin
        n_chk++; n_err++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", guard);
        done = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; ce = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: drives out_ready, checks handshake and pops on each output transfer
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else out_ready = rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      if (reset_n) begin
        chk("in_ready_rule", 32'(ir[0]), 32'(ce & (~ov[0] | out_ready)));
        if (ov[0] && out_ready && ce) begin
          if (q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL unexpected_output: got out_valid=1 acc=0x%0h expected no beat", ga[0]);
          end else begin
            e = q.pop_front();
            for (int c = 0; c < 4; c++) begin
              chk($sformatf("p cfg%0d beat%0d", c, beat_no), gp[c], e.p[c]);
              chk($sformatf("acc cfg%0d beat%0d", c, beat_no), ga[c], e.acc[c]);
              chk($sformatf("ovf cfg%0d beat%0d", c, beat_no), 32'(ovf[c]), 32'(e.ovf[c]));
            end
            chk($sformatf("last beat%0d", beat_no), 32'(ol[0]), 32'(e.last));
            beat_no++;
          end
          if (stall_arm) begin
            stall_arm  = 1'b0;
            stall_left = 3;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    reset_model();
    repeat (3) @(negedge clk);
    #1;
    chk("rst out_valid", 32'(ov[0]), 32'd0);
    chk("rst in_ready", 32'(ir[0]), 32'd0);
    chk("rst dout_p", gp[0], 32'd0);
    chk("rst dout_acc", ga[0], 32'd0);
    chk("rst out_last", 32'(ol[0]), 32'd0);
    chk("rst acc_ovf", 32'(ovf[0]), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Latency: result after the 4th advancing edge
    send(255, 16383, 1'b1, 1'b1, 1'b1);
    idle(0);
    #1 chk("lat edge1", 32'(ov[0]), 32'd0);
    repeat (2) begin
      @(negedge clk);
      #1 chk("lat edge2-3", 32'(ov[0]), 32'd0);
    end
    @(negedge clk);
    #1 chk("lat edge4", 32'(ov[0]), 32'd1);
    @(negedge clk);

    // Signed operand
    send(8'hFF, 100, 1'b1, 1'b1, 1'b0);
    idle(8);

    // Back-to-back accumulation
    send(3, 5, 1'b1, 1'b0, 1'b1);
    send(4, 6, 1'b0, 1'b0, 1'b1);
    send(2, 10, 1'b0, 1'b1, 1'b1);
    idle(8);

    // Saturation then restart
    send(255, 200, 1'b1, 1'b0, 1'b0);
    send(255, 200, 1'b0, 1'b1, 1'b0);
    send(1, 1, 1'b1, 1'b1, 1'b0);
    idle(8);

    // Backpressure: 3-cycle stall after the first output
    stall_arm = 1'b1;
    for (int i = 0; i < 6; i++)
      send(i + 1, 100 * i + 7, i == 0, i == 5, 1'b0);
    idle(14);

    // ce low for two cycles stretches latency by two
    send(9, 9, 1'b1, 1'b1, 1'b0);
    idle(0);
    ce = 1'b0;
    #1 chk("ce_low in_ready", 32'(ir[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    ce = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 chk("ce lat5", 32'(ov[0]), 32'd0);
    @(negedge clk);
    #1 chk("ce lat6", 32'(ov[0]), 32'd1);
    @(negedge clk);

    // Reset with beats in flight
    send(5, 5, 1'b1, 1'b0, 1'b0);
    send(6, 6, 1'b0, 1'b0, 1'b0);
    send(7, 7, 1'b0, 1'b1, 1'b0);
    idle(0);
    reset_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(ov[0]), 32'd0);
    chk("midrst in_ready", 32'(ir[0]), 32'd0);
    reset_model();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      #1 chk("post_rst no_output", 32'(ov[0]), 32'd0);
    end
    @(negedge clk);

    // Randomized stream with random backpressure and ce
    rand_bp = 1'b1;
    rand_ce = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int unsigned a, b;
      a = ($urandom_range(0, 1) != 0) ? 255 - $urandom_range(0, 15) : $urandom_range(0, 255);
      b = ($urandom_range(0, 1) != 0) ? 16383 - $urandom_range(0, 255) : $urandom_range(0, 16383);
      send(a, b, (i == 0) || ($urandom_range(0, 4) == 0), $urandom_range(0, 4) == 0, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        ce = ($urandom_range(0, 4) != 0);
        @(negedge clk);
      end
    end
    rand_ce = 1'b0;
    rand_bp = 1'b0;
    idle(0);

    g = 0;
    while (q.size() != 0 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    chk("drain", 32'(q.size()), 32'd0);
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mul_acc_pipe.md
Name: mul_acc_pipe

Overview:
- Parametrised pipelined multiplier with optional running accumulation; successor to the fixed-width DSP multiplier wrappers used by the area/moment-parameter kernels.
- Adds configurable operand widths, pipeline depth and per-operand signedness.
- Adds a valid/ready handshake with backpressure, frame-delimited accumulation (first/last markers) and optional saturation.
- Sits between the pixel/contour feature stream and the shape-parameter calculators.

Parameters:
- A_WIDTH, 8, width of din0
- B_WIDTH, 14, width of din1
- P_WIDTH, 22, width of dout_p; full product is sign/zero-extended or truncated (LSBs kept) to this width
- NUM_STAGE, 4, latency in advancing cycles; legal range 2..8
- SIGNED_A, 0, 1 = din0 is two's complement
- SIGNED_B, 0, 1 = din1 is two's complement
- ACC_WIDTH, 32, accumulator width; must be >= P_WIDTH
- SAT_EN, 0, 1 = accumulator saturates; 0 = accumulator wraps

Ports:
- clk, input, 1, rising-edge clock
- reset_n, input, 1, asynchronous active-low reset
- ce, input, 1, global clock enable; low freezes every register
- in_valid, input, 1, input beat valid
- in_ready, output, 1, block can accept a beat this cycle
- din0, input, A_WIDTH, multiplicand
- din1, input, B_WIDTH, multiplier
- in_first, input, 1, beat starts a new accumulation
- in_last, input, 1, beat ends the accumulation
- out_valid, output, 1, output beat valid
- out_ready, input, 1, downstream accepts the output beat
- dout_p, output, P_WIDTH, product of this beat
- dout_acc, output, ACC_WIDTH, running sum including this beat
- out_last, output, 1, in_last delayed with the beat
- acc_ovf, output, 1, sticky overflow/saturation flag for the current accumulation

Behaviour:
- Reset (reset_n low, asynchronous):
  - All valid bits, data registers, dout_p, dout_acc, out_last and acc_ovf go to 0.
  - in_ready and out_valid read 0 while reset is asserted.
  - Reset asserted mid-stream discards all in-flight beats; no partial output appears after release.
- Advance: adv = ce & (~out_valid | out_ready).
  - in_ready = adv.
  - An input transfer occurs when in_valid & in_ready.
  - When adv is 0, every register holds its value.
  - When ce is 0, in_ready is 0 and outputs hold stable.
- Pipeline: a NUM_STAGE-deep valid shift register carries each beat together with its first/last tags.
  - Stage 1 registers the operands.
  - Stages 2..NUM_STAGE-1 compute and retime the (A_WIDTH+B_WIDTH)-bit product.
  - Stage NUM_STAGE is the output/accumulate register.
  - Latency: a beat accepted on advancing cycle k appears on out_valid after the NUM_STAGE-th advancing edge.
  - Back-to-back throughput: 1 beat per cycle while out_ready is high.
- Arithmetic:
  - Each operand is extended by its SIGNED_x rule.
  - The product is signed if either SIGNED_A or SIGNED_B is 1, unsigned otherwise.
  - The accumulator uses the same signedness as the product.
- Output-stage update (only on adv with a valid beat in stage NUM_STAGE-1):
  - dout_p <= product.
  - Base = 0 if the beat's first tag is set, else the current dout_acc.
  - dout_acc <= base + ext(product).
  - acc_ovf <= (first ? 0 : acc_ovf) | overflow.
  - Overflow: with SAT_EN=1, the result clamps to the ACC_WIDTH max/min and the flag is set. With SAT_EN=0, the result wraps and the flag still records overflow.
  - Bubbles (invalid beats) do not change dout_p, dout_acc or acc_ovf.
  - out_last follows the beat's last tag.
- Tag cases:
  - first & last on the same beat: dout_acc = that product.
  - first without a preceding last: the accumulation restarts silently.
  - After last, the next beat without first continues summing. Producers must assert first.
- Output hold: while out_valid & ~out_ready, dout_p, dout_acc, out_last and acc_ovf are stable.

Test Plan:
- Unsigned defaults: din0=255, din1=16383, first=last=1 -> out_valid exactly 4 cycles later, dout_p=4177665, dout_acc=4177665, acc_ovf=0.
- SIGNED_A=1: din0=8'hFF, din1=100, first=last=1 -> dout_p=22'h3FFF9C (-100), dout_acc=32'hFFFFFF9C.
- Accumulation: beats (3,5,first), (4,6), (2,10,last) back-to-back -> dout_acc = 15, 39, 59 on consecutive cycles; out_last only on the third beat; in_ready held high throughout.
- Backpressure: stream of 6 beats, out_ready low for 3 cycles after the first output -> in_ready low during the stall, outputs frozen, no beat lost or duplicated, order preserved.
- Saturation: ACC_WIDTH=16, P_WIDTH=16, SAT_EN=1, two beats 255x200 (first, then last) -> dout_acc = 51000, then 65535; acc_ovf=1. The next first beat 1x1 -> dout_acc=1, acc_ovf=0.
- Reset/ce: ce low 2 cycles mid-stream -> latency stretched by 2, values unchanged. reset_n pulsed low with 3 beats in flight -> out_valid=0 immediately, no stale output after release.
